// File: rtl/hdcpu_pkg.sv
// hdcpu shared definitions: beat encodings, run states
// and default widths used by the sequencer and controller.
package hdcpu_pkg;
    localparam int IR_W_DEF  = 8;
    localparam int CNT_W_DEF = 8;

    localparam logic [3:1] W1 = 3'b001;
    localparam logic [3:1] W2 = 3'b010;
    localparam logic [3:1] W3 = 3'b100;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } run_e;
endpackage

// File: rtl/hdcpu_beat_sequencer_if.sv
// Controller <-> beat sequencer bundle: control strobes in,
// beat vector, IR, flags and status out.
interface hdcpu_beat_sequencer_if
    import hdcpu_pkg::*;
#(
    parameter int IR_W  = IR_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             QD;
    logic             SHORT;
    logic             LONG;
    logic             STOP;
    logic             LIR;
    logic             LDC;
    logic             LDZ;
    logic [IR_W-1:0]  D;
    logic             ALU_C;
    logic             ALU_Z;
    logic [3:1]       W;
    logic [IR_W-1:0]  IR;
    logic             C;
    logic             Z;
    logic             RUN;
    logic [CNT_W-1:0] ICOUNT;

    modport master (
        output QD, SHORT, LONG, STOP,
        output LIR, LDC, LDZ, D, ALU_C, ALU_Z,
        input  W, IR, C, Z, RUN, ICOUNT
    );

    modport slave (
        input  QD, SHORT, LONG, STOP,
        input  LIR, LDC, LDZ, D, ALU_C, ALU_Z,
        output W, IR, C, Z, RUN, ICOUNT
    );
endinterface

// File: rtl/hdcpu_beat_fsm.sv
// One-hot beat register W[3:1] with SHORT/LONG advance and
// an instruction-complete strobe on every return to W1.
module hdcpu_beat_fsm
    import hdcpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    input  logic       end_w1,
    input  logic       need_w3,
    output logic [3:1] w,
    output logic       done
);
    logic [3:1] w_q;
    logic [3:1] w_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_q <= W1;
        else        w_q <= w_d;
    end

    // Corrupted beat recovers to W1 even while halted.
    always_comb begin
        w_d  = w_q;
        done = 1'b0;
        if (!$onehot(w_q)) begin
            w_d = W1;
        end else if (adv) begin
            unique case (1'b1)
                w_q[1]: begin
                    if (end_w1) begin
                        w_d  = W1;
                        done = 1'b1;
                    end else begin
                        w_d = W2;
                    end
                end
                w_q[2]: begin
                    if (need_w3) begin
                        w_d = W3;
                    end else begin
                        w_d  = W1;
                        done = 1'b1;
                    end
                end
                w_q[3]: begin
                    w_d  = W1;
                    done = 1'b1;
                end
            endcase
        end
    end

    assign w = w_q;
endmodule

// File: rtl/hdcpu_beat_sequencer.sv
// Beat sequencer: run/halt control, QD start edge, IR and
// C/Z flag registers and completed-instruction counter.
module hdcpu_beat_sequencer
    import hdcpu_pkg::*;
#(
    parameter int IR_W  = IR_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic T3,
    input logic CLR,
    hdcpu_beat_sequencer_if.slave bus
);
    run_e             state_q;
    run_e             state_d;
    logic             qd_q;
    logic             rise;
    logic             run;
    logic             adv;
    logic             done;
    logic [3:1]       w;
    logic [IR_W-1:0]  ir_q;
    logic             c_q;
    logic             z_q;
    logic [CNT_W-1:0] icount_q;

    assign rise = bus.QD & ~qd_q;
    assign run  = (state_q == RUN);
    assign adv  = run & ~bus.STOP;

    // STOP beats a simultaneous start request while running.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HALT: if (rise)     state_d = RUN;
            RUN:  if (bus.STOP) state_d = HALT;
        endcase
    end

    always_ff @(posedge T3 or negedge CLR) begin
        if (!CLR) begin
            state_q <= HALT;
            qd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            qd_q    <= bus.QD;
        end
    end

    hdcpu_beat_fsm u_fsm (
        .clk     (T3),
        .rst_n   (CLR),
        .adv     (adv),
        .end_w1  (bus.SHORT),
        .need_w3 (bus.LONG),
        .w       (w),
        .done    (done)
    );

    // Loads still land on the STOP edge so the last beat completes.
    always_ff @(posedge T3 or negedge CLR) begin
        if (!CLR) begin
            ir_q     <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            icount_q <= '0;
        end else begin
            if (run && bus.LIR) ir_q <= bus.D;
            if (run && bus.LDC) c_q  <= bus.ALU_C;
            if (run && bus.LDZ) z_q  <= bus.ALU_Z;
            if (done) icount_q <= icount_q + CNT_W'(1);
        end
    end

    assign bus.W      = w;
    assign bus.IR     = ir_q;
    assign bus.C      = c_q;
    assign bus.Z      = z_q;
    assign bus.RUN    = run;
    assign bus.ICOUNT = icount_q;
endmodule

// File: tb/tb_hdcpu_beat_sequencer.sv
// Bench for hdcpu_beat_sequencer: directed vector table,
// corner sequences and a randomized run against a beat model.
module tb_hdcpu_beat_sequencer;
    import hdcpu_pkg::*;

    logic t3;
    logic clr;
    int   total;
    int   bad;

    hdcpu_beat_sequencer_if #(.IR_W(8), .CNT_W(8)) bus ();

    hdcpu_beat_sequencer #(.IR_W(8), .CNT_W(8)) dut (
        .T3  (t3),
        .CLR (clr),
        .bus (bus)
    );

    initial t3 = 1'b0;
    always #5 t3 = ~t3;

    typedef struct {
        logic       qd, sh, lo, st, lir, ldc, ldz;
        logic [7:0] d;
        logic       ac, az;
        logic [3:1] w;
        logic       run;
        logic [7:0] ir;
        logic       c, z;
        logic [7:0] ic;
    } vec_t;

    vec_t tv[$];

    // Expected-state model: beat as 1..3 rather than one-hot.
    int   m_beat;
    bit   m_run, m_qdp, m_c, m_z;
    int   m_ir, m_ic;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [3:1] w, logic run,
                           logic [7:0] ir, logic c, logic z,
                           logic [7:0] ic);
        chk({tag, ".W"}, 32'(bus.W), 32'(w));
        chk({tag, ".RUN"}, 32'(bus.RUN), 32'(run));
        chk({tag, ".IR"}, 32'(bus.IR), 32'(ir));
        chk({tag, ".C"}, 32'(bus.C), 32'(c));
        chk({tag, ".Z"}, 32'(bus.Z), 32'(z));
        chk({tag, ".ICOUNT"}, 32'(bus.ICOUNT), 32'(ic));
    endtask

    task automatic drive(logic qd, logic sh, logic lo, logic st,
                         logic lir, logic ldc, logic ldz,
                         logic [7:0] d, logic ac, logic az);
        bus.QD = qd;   bus.SHORT = sh; bus.LONG = lo;
        bus.STOP = st; bus.LIR = lir;  bus.LDC = ldc;
        bus.LDZ = ldz; bus.D = d;      bus.ALU_C = ac;
        bus.ALU_Z = az;
    endtask

    task automatic step();
        @(posedge t3);
        #1;
    endtask

    task automatic add(logic qd, logic sh, logic lo, logic st,
                       logic lir, logic ldc, logic ldz,
                       logic [7:0] d, logic ac, logic az,
                       logic [3:1] w, logic run, logic [7:0] ir,
                       logic c, logic z, logic [7:0] ic);
        vec_t v;
        v.qd = qd; v.sh = sh; v.lo = lo; v.st = st;
        v.lir = lir; v.ldc = ldc; v.ldz = ldz; v.d = d;
        v.ac = ac; v.az = az; v.w = w; v.run = run;
        v.ir = ir; v.c = c; v.z = z; v.ic = ic;
        tv.push_back(v);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);

        //    qd sh lo st lir ldc ldz d      ac az | w   run ir     c  z  ic
        add(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 1, 8'h00, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 1, 8'h00, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 1, 8'h00, 0, 0, 2);
        add(0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 1, 8'h00, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W2, 1, 8'h00, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 1, 8'h00, 0, 0, 4);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W2, 1, 8'h00, 0, 0, 4);
        add(0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0, W3, 1, 8'h00, 0, 0, 4);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 1, 8'h00, 0, 0, 5);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W2, 1, 8'h00, 0, 0, 5);
        add(0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, W2, 0, 8'h00, 0, 0, 5);
        add(0, 0, 0, 0, 1, 0, 0, 8'hA5, 0, 0, W2, 0, 8'h00, 0, 0, 5);
        add(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W2, 1, 8'h00, 0, 0, 5);
        add(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 1, 8'h00, 0, 0, 6);
        add(1, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, W1, 0, 8'h00, 0, 0, 6);
        add(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 0, 8'h00, 0, 0, 6);
        add(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 0, 8'h00, 0, 0, 6);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 0, 8'h00, 0, 0, 6);
        add(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 1, 8'h00, 0, 0, 6);
        add(0, 0, 0, 0, 1, 1, 0, 8'h3C, 1, 1, W2, 1, 8'h3C, 1, 0, 6);
        add(0, 0, 0, 1, 1, 0, 0, 8'h5A, 0, 0, W2, 0, 8'h5A, 1, 0, 6);
        add(1, 0, 0, 1, 1, 0, 0, 8'hFF, 0, 0, W2, 1, 8'h5A, 1, 0, 6);
        add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 1, 8'h5A, 1, 0, 7);
        add(1, 0, 0, 1, 0, 0, 1, 8'h00, 0, 1, W1, 0, 8'h5A, 1, 1, 7);
        add(0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, W1, 0, 8'h5A, 1, 1, 7);
        add(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 1, 8'h5A, 1, 1, 7);
        add(0, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, W1, 1, 8'h5A, 1, 1, 8);
        add(0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0, W2, 1, 8'h5A, 1, 1, 8);
        add(0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, W1, 1, 8'h5A, 1, 1, 9);

        repeat (2) @(posedge t3);
        #1;
        chk_all("reset", W1, 0, 8'h00, 0, 0, 8'h00);
        @(negedge t3);
        clr = 1'b1;

        foreach (tv[i]) begin
            drive(tv[i].qd, tv[i].sh, tv[i].lo, tv[i].st,
                  tv[i].lir, tv[i].ldc, tv[i].ldz, tv[i].d,
                  tv[i].ac, tv[i].az);
            step();
            chk_all($sformatf("vec%0d", i), tv[i].w, tv[i].run,
                    tv[i].ir, tv[i].c, tv[i].z, tv[i].ic);
        end

        // Build up W3 / IR=FF / C=Z=1 / ICOUNT=7F, then reset between edges.
        drive(0, 1, 0, 0, 1, 1, 1, 8'hFF, 1, 1);
        step();
        drive(0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        repeat (8'h7F - 10) step();
        drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        step();
        drive(0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0);
        step();
        chk_all("pre_rst", W3, 1, 8'hFF, 1, 1, 8'h7F);
        drive(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        #2;
        clr = 1'b0;
        #1;
        chk_all("async_rst", W1, 0, 8'h00, 0, 0, 8'h00);
        @(negedge t3);
        clr = 1'b1;
        step();
        chk("qd_hist_cleared", 32'(bus.RUN), 32'd1);

        drive(0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        repeat (255) step();
        chk("icount_ff", 32'(bus.ICOUNT), 32'hFF);
        step();
        chk("icount_wrap", 32'(bus.ICOUNT), 32'h00);

        drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        force dut.u_fsm.w_q = 3'b110;
        #2;
        release dut.u_fsm.w_q;
        chk("illegal_seen", 32'(bus.W), 32'(3'b110));
        step();
        chk("illegal_fix", 32'(bus.W), 32'(W1));
        chk("illegal_nocnt", 32'(bus.ICOUNT), 32'h00);

        drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        #2;
        clr = 1'b0;
        #1;
        clr = 1'b1;
        m_beat = 1; m_run = 0; m_qdp = 0;
        m_c = 0; m_z = 0; m_ir = 0; m_ic = 0;
        for (int n = 0; n < 800; n++) begin
            bit qd, sh, lo, st, lir, ldc, ldz, ac, az, rise;
            int d;
            qd  = ($urandom % 4) == 0;
            sh  = ($urandom % 3) == 0;
            lo  = $urandom % 2;
            st  = ($urandom % 8) == 0;
            lir = $urandom % 2;
            ldc = $urandom % 2;
            ldz = $urandom % 2;
            ac  = $urandom % 2;
            az  = $urandom % 2;
            d   = $urandom % 256;
            drive(qd, sh, lo, st, lir, ldc, ldz, 8'(d), ac, az);
            rise = qd && !m_qdp;
            if (m_run) begin
                if (lir) m_ir = d;
                if (ldc) m_c = ac;
                if (ldz) m_z = az;
                if (!st) begin
                    if (m_beat == 1 && !sh) m_beat = 2;
                    else if (m_beat == 2 && lo) m_beat = 3;
                    else begin
                        m_beat = 1;
                        m_ic = (m_ic + 1) % 256;
                    end
                end
                m_run = !st;
            end else begin
                m_run = rise;
            end
            m_qdp = qd;
            step();
            chk_all($sformatf("rnd%0d", n), 3'(1 << (m_beat - 1)),
                    m_run, 8'(m_ir), m_c, m_z, 8'(m_ic));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
